pixel_stream_packer: RTL and testbench

//  Downstream stage of the output buffer. In the CLK domain it captures bus words

---
 rtl/pixel_stream_packer.sv | 200 ++++++++++++++++++++
 tb/tb_pixel_stream_packer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_packer.sv
// Tags captured bus words with SOF/EOL/EOF frame position and queues them for the host (macro FRAME_COUNT_EN adds a frame counter).
// Latency: a word written at edge N is presented at OUT_* right after edge N (one cycle, no empty bypass).
// Backpressure: OUT_READY low holds the head word stable; a word arriving on a full FIFO is dropped and OVERFLOW set.
`timescale 1ns/1ps

module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   core_clk,
    input  logic                   arst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge core_clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
endmodule

module pixel_stream_packer #(
    parameter int WORD_BITS       = 16,
    parameter int WORDS_PER_LINE  = 2,
    parameter int LINES_PER_FRAME = 4,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          FRAME_SYNC,
    input  logic                          IN_VALID,
    input  logic [WORD_BITS-1:0]          DATA_IN,
    input  logic                          OUT_READY,
    input  logic                          CLEAR_ERR,
    output logic                          OUT_VALID,
    output logic [WORD_BITS-1:0]          OUT_DATA,
    output logic                          OUT_SOF,
    output logic                          OUT_EOL,
    output logic                          OUT_EOF,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          OVERFLOW,
    output logic                          FRAME_ERR
`ifdef FRAME_COUNT_EN
    ,
    output logic [15:0]                   FRAME_COUNT
`endif
);
    localparam int WCW = (WORDS_PER_LINE  > 1) ? $clog2(WORDS_PER_LINE)  : 1;
    localparam int LCW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

    typedef struct packed {
        logic                 sof;
        logic                 eol;
        logic                 eof;
        logic [WORD_BITS-1:0] dat;
    } entry_t;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WCW-1:0] word_cnt;
    logic [LCW-1:0] line_cnt;
    logic [WCW-1:0] word_eff;
    logic [LCW-1:0] line_eff;

    logic   in_frame;
    logic   take;
    logic   tag_sof;
    logic   tag_eol;
    logic   tag_eof;
    logic   push;
    logic   pop;
    logic   drop;
    logic   sync_err;
    logic   fifo_full;
    logic   fifo_empty;
    entry_t wr_entry;
    entry_t head_entry;

    // A sync pulse restarts position, so the word arriving with it is tagged as SOF.
    assign word_eff = FRAME_SYNC ? '0 : word_cnt;
    assign line_eff = FRAME_SYNC ? '0 : line_cnt;

    assign in_frame = (state == ACTIVE) || FRAME_SYNC;
    assign take     = in_frame && IN_VALID;
    assign tag_sof  = (word_eff == '0) && (line_eff == '0);
    assign tag_eol  = (word_eff == WCW'(WORDS_PER_LINE - 1));
    assign tag_eof  = tag_eol && (line_eff == LCW'(LINES_PER_FRAME - 1));

    assign pop      = !fifo_empty && OUT_READY;
    assign push     = take && (!fifo_full || pop);
    assign drop     = take && fifo_full && !pop;
    assign sync_err = FRAME_SYNC && (state == ACTIVE) && ((word_cnt != '0) || (line_cnt != '0));

    assign wr_entry.sof = tag_sof;
    assign wr_entry.eol = tag_eol;
    assign wr_entry.eof = tag_eof;
    assign wr_entry.dat = DATA_IN;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (FRAME_SYNC) state_nxt = ACTIVE;
            ACTIVE:  state_nxt = ACTIVE;
            default: state_nxt = IDLE;
        endcase
        // The EOF position closes the frame even when the word itself was dropped.
        if (take && tag_eof) state_nxt = IDLE;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            word_cnt <= '0;
            line_cnt <= '0;
        end else if (take) begin
            if (tag_eol) begin
                word_cnt <= '0;
                line_cnt <= tag_eof ? '0 : line_eff + LCW'(1);
            end else begin
                word_cnt <= word_eff + WCW'(1);
                line_cnt <= line_eff;
            end
        end else if (FRAME_SYNC) begin
            word_cnt <= '0;
            line_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            OVERFLOW  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            if (drop)           OVERFLOW  <= 1'b1;
            else if (CLEAR_ERR) OVERFLOW  <= 1'b0;
            if (sync_err)       FRAME_ERR <= 1'b1;
            else if (CLEAR_ERR) FRAME_ERR <= 1'b0;
        end
    end

`ifdef FRAME_COUNT_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)              FRAME_COUNT <= '0;
        else if (push && tag_eof) FRAME_COUNT <= FRAME_COUNT + 16'd1;
    end
`endif

    fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (CLK),
        .arst_n   (RESET),
        .push     (push),
        .push_dat (wr_entry),
        .pop      (pop),
        .head_dat (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (FIFO_LEVEL)
    );

    // Storage is not reset, so the head is masked until something is queued.
    assign OUT_VALID = !fifo_empty;
    assign OUT_DATA  = fifo_empty ? '0   : head_entry.dat;
    assign OUT_SOF   = fifo_empty ? 1'b0 : head_entry.sof;
    assign OUT_EOL   = fifo_empty ? 1'b0 : head_entry.eol;
    assign OUT_EOF   = fifo_empty ? 1'b0 : head_entry.eof;
endmodule

// File: tb/tb_pixel_stream_packer.sv
// Scoreboard bench for pixel_stream_packer: stimulus queues expected words, a negedge monitor checks every pop.
`timescale 1ns/1ps

module tb_pixel_stream_packer;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        FRAME_SYNC = 1'b0;
    logic        IN_VALID = 1'b0;
    logic [15:0] DATA_IN = '0;
    logic        OUT_READY = 1'b0;
    logic        CLEAR_ERR = 1'b0;
    logic        OUT_VALID;
    logic [15:0] OUT_DATA;
    logic        OUT_SOF;
    logic        OUT_EOL;
    logic        OUT_EOF;
    logic [3:0]  FIFO_LEVEL;
    logic        OVERFLOW;
    logic        FRAME_ERR;
`ifdef FRAME_COUNT_EN
    logic [15:0] FRAME_COUNT;
`endif

    typedef struct packed {
        logic [15:0] dat;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pixel_stream_packer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .FRAME_SYNC (FRAME_SYNC),
        .IN_VALID   (IN_VALID),
        .DATA_IN    (DATA_IN),
        .OUT_READY  (OUT_READY),
        .CLEAR_ERR  (CLEAR_ERR),
        .OUT_VALID  (OUT_VALID),
        .OUT_DATA   (OUT_DATA),
        .OUT_SOF    (OUT_SOF),
        .OUT_EOL    (OUT_EOL),
        .OUT_EOF    (OUT_EOF),
        .FIFO_LEVEL (FIFO_LEVEL),
        .OVERFLOW   (OVERFLOW),
        .FRAME_ERR  (FRAME_ERR)
`ifdef FRAME_COUNT_EN
        ,
        .FRAME_COUNT (FRAME_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {16'h0, OUT_DATA}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", {16'h0, OUT_DATA}, {16'h0, e.dat});
                chk("out_tags", {29'h0, OUT_SOF, OUT_EOL, OUT_EOF}, {29'h0, e.sof, e.eol, e.eof});
            end
        end
    end

    // Tags for a 2-word-line, 4-line frame; idx < 0 marks a word outside any frame.
    task automatic send(input logic [15:0] d, input logic sync, input int idx, input logic kept);
        exp_t e;
        FRAME_SYNC = sync;
        IN_VALID   = 1'b1;
        DATA_IN    = d;
        if (kept) begin
            e.dat = d;
            e.sof = (idx == 0);
            e.eol = (idx % 2 == 1);
            e.eof = (idx == 7);
            sb.push_back(e);
        end
        @(posedge CLK); #1;
        IN_VALID   = 1'b0;
        FRAME_SYNC = 1'b0;
    endtask

    task automatic pulse_sync();
        FRAME_SYNC = 1'b1;
        @(posedge CLK); #1;
        FRAME_SYNC = 1'b0;
    endtask

    task automatic pulse_clear();
        CLEAR_ERR = 1'b1;
        @(posedge CLK); #1;
        CLEAR_ERR = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic frame(input logic [15:0] base, input logic kept);
        for (int i = 0; i < 8; i++) send(base + 16'(i), 1'b0, i, kept);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        idle(2);
        chk("rst_valid", {31'h0, OUT_VALID}, 0);
        chk("rst_level", {28'h0, FIFO_LEVEL}, 0);
        chk("rst_data",  {16'h0, OUT_DATA}, 0);
        chk("rst_flags", {30'h0, OVERFLOW, FRAME_ERR}, 0);
        RESET = 1'b1;
        idle(1);

        // Words before any sync are ignored.
        send(16'hAAAA, 1'b0, -1, 1'b0);
        send(16'hAAAB, 1'b0, -1, 1'b0);
        chk("idle_level", {28'h0, FIFO_LEVEL}, 0);
        chk("idle_valid", {31'h0, OUT_VALID}, 0);

        // Contiguous frame with the host always ready.
        OUT_READY = 1'b1;
        pulse_sync();
        chk("pre_valid", {31'h0, OUT_VALID}, 0);
        send(16'h0001, 1'b0, 0, 1'b1);
        chk("latency_valid", {31'h0, OUT_VALID}, 1);
        for (int i = 1; i < 8; i++) send(16'h0001 + 16'(i), 1'b0, i, 1'b1);
        idle(4);
        chk("t1_drained", {28'h0, FIFO_LEVEL}, 0);
        send(16'h5555, 1'b0, -1, 1'b0);
        chk("t1_back_idle", {28'h0, FIFO_LEVEL}, 0);

        // Host stalled: first frame fills the FIFO, whole second frame is dropped.
        OUT_READY = 1'b0;
        pulse_sync();
        frame(16'h0011, 1'b1);
        chk("t2_full", {28'h0, FIFO_LEVEL}, 8);
        chk("t2_no_ovf", {31'h0, OVERFLOW}, 0);
        chk("t2_head", {16'h0, OUT_DATA}, 16'h0011);
        chk("t2_head_sof", {31'h0, OUT_SOF}, 1);
        pulse_sync();
        frame(16'h0021, 1'b0);
        chk("t2_ovf", {31'h0, OVERFLOW}, 1);
        chk("t2_level", {28'h0, FIFO_LEVEL}, 8);
        chk("t2_stable", {16'h0, OUT_DATA}, 16'h0011);
        OUT_READY = 1'b1;
        idle(10);
        chk("t2_drained", {28'h0, FIFO_LEVEL}, 0);
        send(16'h0099, 1'b0, -1, 1'b0);
        chk("t2_framing", {28'h0, FIFO_LEVEL}, 0);
        pulse_clear();
        chk("t2_clear", {31'h0, OVERFLOW}, 0);

        // Push and pop on a full FIFO must not drop.
        OUT_READY = 1'b0;
        pulse_sync();
        frame(16'h0031, 1'b1);
        chk("t3_full", {28'h0, FIFO_LEVEL}, 8);
        pulse_sync();
        OUT_READY = 1'b1;
        send(16'h0041, 1'b0, 0, 1'b1);
        chk("t3_level", {28'h0, FIFO_LEVEL}, 8);
        chk("t3_no_ovf", {31'h0, OVERFLOW}, 0);
        for (int i = 1; i < 8; i++) send(16'h0041 + 16'(i), 1'b0, i, 1'b1);
        chk("t3_level_end", {28'h0, FIFO_LEVEL}, 8);
        idle(12);
        chk("t3_drained", {28'h0, FIFO_LEVEL}, 0);
        chk("t3_no_ovf_end", {31'h0, OVERFLOW}, 0);

        // Sync mid-frame, coinciding with the next word.
        pulse_sync();
        send(16'h0051, 1'b0, 0, 1'b1);
        send(16'h0052, 1'b0, 1, 1'b1);
        send(16'h0053, 1'b0, 2, 1'b1);
        chk("t4_no_err", {31'h0, FRAME_ERR}, 0);
        for (int i = 0; i < 8; i++) send(16'h0061 + 16'(i), (i == 0), i, 1'b1);
        chk("t4_err", {31'h0, FRAME_ERR}, 1);
        pulse_clear();
        chk("t4_clear", {31'h0, FRAME_ERR}, 0);
        idle(4);
`ifdef FRAME_COUNT_EN
        chk("frame_count", {16'h0, FRAME_COUNT}, 5);
`endif

        // Reset in the middle of a frame.
        OUT_READY = 1'b0;
        pulse_sync();
        send(16'h0071, 1'b0, 0, 1'b1);
        send(16'h0072, 1'b0, 1, 1'b1);
        send(16'h0073, 1'b0, 2, 1'b1);
        pulse_sync();
        chk("t5_level", {28'h0, FIFO_LEVEL}, 3);
        chk("t5_err", {31'h0, FRAME_ERR}, 1);
        RESET = 1'b0;
        #1;
        chk("t5_rst_valid", {31'h0, OUT_VALID}, 0);
        chk("t5_rst_level", {28'h0, FIFO_LEVEL}, 0);
        chk("t5_rst_data", {16'h0, OUT_DATA}, 0);
        chk("t5_rst_tags", {29'h0, OUT_SOF, OUT_EOL, OUT_EOF}, 0);
        chk("t5_rst_flags", {30'h0, OVERFLOW, FRAME_ERR}, 0);
`ifdef FRAME_COUNT_EN
        chk("t5_rst_count", {16'h0, FRAME_COUNT}, 0);
`endif
        sb.delete();
        idle(2);
        RESET = 1'b1;
        send(16'hBBBB, 1'b0, -1, 1'b0);
        chk("t5_idle_after_rst", {28'h0, FIFO_LEVEL}, 0);

        idle(3);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
